// File: rtl/gem_fiber_in.sv
// Receive-side deframer for the GEM trigger fiber: acquires A/B frame alignment on the K-code separator,
// reassembles the 56-bit payload, tracks the BC/F7/FB/FD rotation and keeps saturating error counters.
module gem_fiber_in #(
    parameter int LOCK_FRAMES = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 TRG_CLK80,
    input  logic                 TRG_RST,
    input  logic [31:0]          RX_DATA,
    input  logic [3:0]           RX_ISK,
    input  logic                 RX_READY,
    input  logic                 ERR_CNT_RST,
    output logic [55:0]          GEM_DATA,
    output logic                 GEM_OVERFLOW,
    output logic                 DATA_VALID,
    output logic                 LINK_LOCKED,
    output logic                 IDLE_SEEN,
    output logic [CNT_WIDTH-1:0] FRAME_ERR_CNT,
    output logic [CNT_WIDTH-1:0] SEQ_ERR_CNT,
    output logic [CNT_WIDTH-1:0] UNLOCK_CNT
);

    localparam logic [7:0]  K_BC = 8'hBC;
    localparam logic [7:0]  K_F7 = 8'hF7;
    localparam logic [7:0]  K_FB = 8'hFB;
    localparam logic [7:0]  K_FD = 8'hFD;
    localparam logic [7:0]  K_FC = 8'hFC;
    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    // The acquiring B word already completes one frame, so VERIFY needs LOCK_FRAMES-1 more.
    localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_FRAMES - 2);
    localparam logic [7:0]  UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

    function automatic logic [7:0] f_succ(input logic [7:0] sep);
        case (sep)
            K_BC:    f_succ = K_F7;
            K_F7:    f_succ = K_FB;
            K_FB:    f_succ = K_FD;
            default: f_succ = K_BC;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        f_sat_inc = (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    state_t                r_state;
    logic                  r_phase;      // 0 = expecting A word, 1 = expecting B word
    logic [7:0]            r_exp_sep;
    logic [7:0]            r_good_cnt;
    logic [7:0]            r_bad_run;
    logic [31:0]           r_word_a;
    logic                  r_a_ok;
    logic [55:0]           r_gem_data;
    logic                  r_gem_ovf;
    logic                  r_valid;
    logic                  r_idle;
    logic [CNT_WIDTH-1:0]  r_frame_err_cnt;
    logic [CNT_WIDTH-1:0]  r_seq_err_cnt;
    logic [CNT_WIDTH-1:0]  r_unlock_cnt;

    logic [7:0] w_sep;
    logic       w_sep_ok;
    logic       w_is_a;
    logic       w_is_b;
    logic       w_is_idle;
    logic       w_good;
    logic       w_seq_mis;
    logic [7:0] w_exp_adv;

    state_t     w_state_nx;
    logic       w_phase_nx;
    logic [7:0] w_exp_nx;
    logic [7:0] w_good_nx;
    logic [7:0] w_bad_nx;
    logic       w_store_a;
    logic       w_deliver;
    logic       w_frame_err;
    logic       w_seq_err;
    logic       w_unlock;

    assign w_sep     = RX_DATA[7:0];
    assign w_sep_ok  = (w_sep == K_BC) || (w_sep == K_F7) || (w_sep == K_FB) ||
                       (w_sep == K_FD) || (w_sep == K_FC);
    assign w_is_a    = (RX_ISK == 4'b0000);
    assign w_is_b    = (RX_ISK == 4'b0001) && w_sep_ok;
    assign w_is_idle = (RX_DATA == IDLE_WORD) && (RX_ISK == 4'b0101);
    assign w_good    = r_a_ok && w_is_b;
    // FC stands in for whatever separator was due, so it never counts as a rotation error.
    assign w_seq_mis = (w_sep != K_FC) && (w_sep != r_exp_sep);
    assign w_exp_adv = (w_sep == K_FC) ? f_succ(r_exp_sep) : f_succ(w_sep);

    always_comb begin
        w_state_nx  = r_state;
        w_phase_nx  = ~r_phase;
        w_exp_nx    = r_exp_sep;
        w_good_nx   = r_good_cnt;
        w_bad_nx    = r_bad_run;
        w_store_a   = 1'b0;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        w_seq_err   = 1'b0;
        w_unlock    = 1'b0;
        if (!RX_READY) begin
            w_state_nx = ST_HUNT;
            w_phase_nx = 1'b0;
            w_unlock   = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_HUNT: begin
                    w_phase_nx = 1'b0;
                    if (w_is_b) begin
                        w_state_nx = ST_VERIFY;
                        w_exp_nx   = w_exp_adv;
                        w_good_nx  = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    if (w_is_idle) begin
                        w_state_nx = ST_HUNT;
                        w_phase_nx = 1'b0;
                    end else if (!r_phase) begin
                        w_store_a = 1'b1;
                    end else if (w_good) begin
                        w_exp_nx = w_exp_adv;
                        if (r_good_cnt == LOCK_LAST) begin
                            w_state_nx = ST_LOCKED;
                            w_bad_nx   = 8'd0;
                        end else begin
                            w_good_nx = r_good_cnt + 8'd1;
                        end
                    end else begin
                        w_state_nx = ST_HUNT;
                        w_phase_nx = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (w_is_idle) begin
                        w_state_nx = ST_HUNT;
                        w_phase_nx = 1'b0;
                    end else if (!r_phase) begin
                        w_store_a = 1'b1;
                    end else if (w_good) begin
                        w_deliver = 1'b1;
                        w_exp_nx  = w_exp_adv;
                        w_seq_err = w_seq_mis;
                        w_bad_nx  = 8'd0;
                    end else begin
                        w_frame_err = 1'b1;
                        if (r_bad_run == UNLOCK_LAST) begin
                            w_state_nx = ST_HUNT;
                            w_phase_nx = 1'b0;
                            w_unlock   = 1'b1;
                        end else begin
                            w_bad_nx = r_bad_run + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                    w_phase_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge TRG_CLK80) begin
        if (TRG_RST) begin
            r_state         <= ST_HUNT;
            r_phase         <= 1'b0;
            r_exp_sep       <= K_BC;
            r_good_cnt      <= 8'd0;
            r_bad_run       <= 8'd0;
            r_word_a        <= 32'd0;
            r_a_ok          <= 1'b0;
            r_gem_data      <= 56'd0;
            r_gem_ovf       <= 1'b0;
            r_valid         <= 1'b0;
            r_idle          <= 1'b0;
            r_frame_err_cnt <= '0;
            r_seq_err_cnt   <= '0;
            r_unlock_cnt    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_phase    <= w_phase_nx;
            r_exp_sep  <= w_exp_nx;
            r_good_cnt <= w_good_nx;
            r_bad_run  <= w_bad_nx;
            if (w_store_a) begin
                r_word_a <= RX_DATA;
                r_a_ok   <= w_is_a;
            end
            r_valid <= w_deliver;
            if (w_deliver) begin
                r_gem_data <= {r_word_a, RX_DATA[31:8]};
                r_gem_ovf  <= (w_sep == K_FC);
            end
            r_idle <= RX_READY && w_is_idle;
            if (ERR_CNT_RST) begin
                r_frame_err_cnt <= '0;
                r_seq_err_cnt   <= '0;
                r_unlock_cnt    <= '0;
            end else begin
                if (w_frame_err) r_frame_err_cnt <= f_sat_inc(r_frame_err_cnt);
                if (w_seq_err)   r_seq_err_cnt   <= f_sat_inc(r_seq_err_cnt);
                if (w_unlock)    r_unlock_cnt    <= f_sat_inc(r_unlock_cnt);
            end
        end
    end

    assign GEM_DATA      = r_gem_data;
    assign GEM_OVERFLOW  = r_gem_ovf;
    assign DATA_VALID    = r_valid;
    assign LINK_LOCKED   = (r_state == ST_LOCKED);
    assign IDLE_SEEN     = r_idle;
    assign FRAME_ERR_CNT = r_frame_err_cnt;
    assign SEQ_ERR_CNT   = r_seq_err_cnt;
    assign UNLOCK_CNT    = r_unlock_cnt;

endmodule

// File: tb/tb_gem_fiber_in.sv
// Directed bench for gem_fiber_in: lock, overflow, rotation error, unlock, idle, saturation and clear.
// Counters are built 4 bits wide so saturation is reachable with a short stimulus.
module tb_gem_fiber_in;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   rx_data;
    logic [3:0]    rx_isk;
    logic          rx_ready;
    logic          err_cnt_rst;
    logic [55:0]   gem_data;
    logic          gem_ovf;
    logic          data_valid;
    logic          link_locked;
    logic          idle_seen;
    logic [CW-1:0] frame_err_cnt;
    logic [CW-1:0] seq_err_cnt;
    logic [CW-1:0] unlock_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] rot [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
    int sidx = 0;

    always #5 clk = ~clk;

    gem_fiber_in #(.LOCK_FRAMES(8), .UNLOCK_ERRS(4), .CNT_WIDTH(CW)) dut (
        .TRG_CLK80    (clk),
        .TRG_RST      (rst),
        .RX_DATA      (rx_data),
        .RX_ISK       (rx_isk),
        .RX_READY     (rx_ready),
        .ERR_CNT_RST  (err_cnt_rst),
        .GEM_DATA     (gem_data),
        .GEM_OVERFLOW (gem_ovf),
        .DATA_VALID   (data_valid),
        .LINK_LOCKED  (link_locked),
        .IDLE_SEEN    (idle_seen),
        .FRAME_ERR_CNT(frame_err_cnt),
        .SEQ_ERR_CNT  (seq_err_cnt),
        .UNLOCK_CNT   (unlock_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge; return 1 time unit after the sampling edge.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        rx_data = d;
        rx_isk  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [23:0] b, input logic [7:0] sep);
        send_word(a, 4'b0000);
        send_word({b, sep}, 4'b0001);
    endtask

    task automatic send_rot_frame();
        send_frame(32'hDEADBEEF, 24'h123456, rot[sidx]);
        sidx = (sidx + 1) % 4;
    endtask

    task automatic send_bad_frame();
        send_word(32'hDEADBEEF, 4'b0000);
        send_word(32'h123456BC, 4'b0000);
    endtask

    initial begin
        rst = 1'b1; rx_data = 32'd0; rx_isk = 4'd0; rx_ready = 1'b1; err_cnt_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",  64'(data_valid),    64'd0);
        chk("rst_locked", 64'(link_locked),   64'd0);
        chk("rst_data",   64'(gem_data),      64'd0);
        chk("rst_ferr",   64'(frame_err_cnt), 64'd0);
        chk("rst_idle",   64'(idle_seen),     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock after the 8th B word
        for (int i = 0; i < 7; i++) send_rot_frame();
        chk("lock_7th", 64'(link_locked), 64'd0);
        send_rot_frame();
        chk("lock_8th",  64'(link_locked), 64'd1);
        chk("lock_noval", 64'(data_valid), 64'd0);
        send_word(32'hDEADBEEF, 4'b0000);
        chk("f9_a_noval", 64'(data_valid), 64'd0);
        send_word({24'h123456, rot[sidx]}, 4'b0001);
        sidx = (sidx + 1) % 4;
        chk("f9_valid", 64'(data_valid), 64'd1);
        chk("f9_data",  64'(gem_data),   64'h00DEADBEEF123456);
        chk("f9_ovf",   64'(gem_ovf),    64'd0);

        // Overflow separator in place of FB
        send_rot_frame();
        send_frame(32'hDEADBEEF, 24'h123456, 8'hFC);
        sidx = (sidx + 1) % 4;
        chk("ovf_valid", 64'(data_valid), 64'd1);
        chk("ovf_flag",  64'(gem_ovf),    64'd1);
        send_frame(32'h01234567, 24'h89ABCD, 8'hFD);
        sidx = 0;
        chk("fd_valid", 64'(data_valid), 64'd1);
        chk("fd_ovf",   64'(gem_ovf),    64'd0);
        chk("fd_data",  64'(gem_data),   64'h000123456789ABCD);
        chk("fd_seq",   64'(seq_err_cnt), 64'd0);

        // Rotation error BC,F7,BC then F7
        send_frame(32'hDEADBEEF, 24'h123456, 8'hBC);
        send_frame(32'hDEADBEEF, 24'h123456, 8'hF7);
        send_frame(32'hDEADBEEF, 24'h123456, 8'hBC);
        chk("rot_seq",   64'(seq_err_cnt), 64'd1);
        chk("rot_valid", 64'(data_valid),  64'd1);
        send_frame(32'hDEADBEEF, 24'h123456, 8'hF7);
        chk("rot_resync_seq",   64'(seq_err_cnt), 64'd1);
        chk("rot_resync_valid", 64'(data_valid),  64'd1);
        sidx = 2;

        // Three bad, one good, then four bad
        for (int i = 0; i < 3; i++) send_bad_frame();
        chk("bad3_ferr",   64'(frame_err_cnt), 64'd3);
        chk("bad3_noval",  64'(data_valid),    64'd0);
        chk("bad3_locked", 64'(link_locked),   64'd1);
        send_rot_frame();
        chk("good_valid",  64'(data_valid),  64'd1);
        chk("good_locked", 64'(link_locked), 64'd1);
        for (int i = 0; i < 3; i++) send_bad_frame();
        chk("bad7_locked", 64'(link_locked), 64'd1);
        send_bad_frame();
        chk("unl_locked", 64'(link_locked),   64'd0);
        chk("unl_cnt",    64'(unlock_cnt),    64'd1);
        chk("unl_ferr",   64'(frame_err_cnt), 64'd7);

        // Relock, then idle words drop to HUNT silently
        sidx = 0;
        for (int i = 0; i < 8; i++) send_rot_frame();
        chk("relock1", 64'(link_locked), 64'd1);
        for (int i = 0; i < 10; i++) begin
            send_word(32'h50BC50BC, 4'b0101);
            chk($sformatf("idle_%0d", i), 64'(idle_seen), 64'd1);
        end
        chk("idle_locked", 64'(link_locked),   64'd0);
        chk("idle_unl",    64'(unlock_cnt),    64'd1);
        chk("idle_ferr",   64'(frame_err_cnt), 64'd7);
        chk("idle_seq",    64'(seq_err_cnt),   64'd1);
        sidx = 0;
        send_rot_frame();
        chk("idle_drop", 64'(idle_seen), 64'd0);
        for (int i = 0; i < 6; i++) send_rot_frame();
        chk("relock_7th", 64'(link_locked), 64'd0);
        send_rot_frame();
        chk("relock_8th", 64'(link_locked), 64'd1);

        // Saturate FRAME_ERR_CNT (4 bits) without unlocking
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) send_bad_frame();
            send_rot_frame();
        end
        send_bad_frame();
        send_bad_frame();
        send_rot_frame();
        chk("sat_reach", 64'(frame_err_cnt), 64'd15);
        send_bad_frame();
        chk("sat_hold",   64'(frame_err_cnt), 64'd15);
        chk("sat_locked", 64'(link_locked),   64'd1);

        // Clear wins over a coincident increment
        send_word(32'hDEADBEEF, 4'b0000);
        @(negedge clk);
        rx_data = 32'h123456BC; rx_isk = 4'b0000; err_cnt_rst = 1'b1;
        @(posedge clk);
        #1;
        err_cnt_rst = 1'b0;
        chk("clr_ferr", 64'(frame_err_cnt), 64'd0);
        chk("clr_seq",  64'(seq_err_cnt),   64'd0);
        chk("clr_unl",  64'(unlock_cnt),    64'd0);

        // RX_READY low while locked
        @(negedge clk);
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_locked", 64'(link_locked), 64'd0);
        chk("rdy_unl",    64'(unlock_cnt),  64'd1);
        chk("rdy_valid",  64'(data_valid),  64'd0);
        @(negedge clk);
        rx_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
